// File: rtl/pipeline_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared types and constants for the pipeline hold/flush sequencer.
//   - state_t : sequencer states (RUN, MUL_WAIT, EXC_DRAIN)
//   - PC_SEL_*: next-PC source encodings driven on pc_sel
//   - ctrl_t  : bundle of the per-cycle stall/flush/pc_sel controls
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MUL_WAIT  = 2'd1,
        EXC_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;  // PC + 4
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;  // branch / jump target
    localparam logic [1:0] PC_SEL_EXC    = 2'b10;  // exception vector
    localparam logic [1:0] PC_SEL_EPC    = 2'b11;  // saved EPC

    typedef struct packed {
        logic       pc_stall;
        logic       ifid_stall;
        logic       ifid_flush;
        logic       idex_stall;
        logic       idex_flush;
        logic       exmem_stall;
        logic       exmem_flush;
        logic [1:0] pc_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{pc_sel: PC_SEL_SEQ, default: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
//   Combinational load-use detector: the instruction in ID reads a register
//   that the load currently in EX has not yet produced.
//   Ports:
//     id_rs1, id_rs2           source registers of the ID instruction
//     id_uses_rs1, id_uses_rs2 which sources the ID instruction really reads
//     ex_rd                    destination of the EX instruction
//     ex_mem_read              EX instruction is a load
//     load_use                 1 = ID must wait one cycle for the load data
// ----------------------------------------------------------------------------
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//   Central hold/flush sequencer for the in-order 5-stage core. Decides, each
//   cycle, stall and flush for PC, IF/ID, ID/EX and EX/MEM, selects the next-PC
//   source and tracks supervisor mode.
//   Parameters:
//     MUL_LATENCY  cycles a multiply occupies EX (>= 2)
//     DRAIN_CYCLES cycles the front end is held after an exception (>= 1)
//   Ports:
//     clk, reset                   clock, synchronous active-high reset
//     id_*                         ID-stage operand usage (load-use check)
//     ex_rd, ex_mem_read           EX-stage load destination
//     ex_is_mul, ex_branch_taken   EX-stage multiply / taken branch
//     d_cache_stall, rob_full      back-pressure from memory and ROB
//     exc_valid, exc_return        commit-time exception / handler return
//     *_stall, *_flush             pipeline register controls
//     pc_sel                       next-PC source (see PC_SEL_* in package)
//     supervisor_mode              current privilege (1 = supervisor)
//     stall_count                  cycles with pc_stall = 1 (wraps)
//   Control outputs are combinational from registered state and the current
//   inputs; state, cnt, supervisor_mode and stall_count are registered.
// ----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY  = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_is_mul,
    input  logic        ex_branch_taken,
    input  logic        d_cache_stall,
    input  logic        rob_full,
    input  logic        exc_valid,
    input  logic        exc_return,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_stall,
    output logic        idex_flush,
    output logic        exmem_stall,
    output logic        exmem_flush,
    output logic [1:0]  pc_sel,
    output logic        supervisor_mode,
    output logic [31:0] stall_count
);

    localparam int CNT_MAX = (MUL_LATENCY > DRAIN_CYCLES) ? MUL_LATENCY : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MUL_CNT_INIT   = CNT_W'(MUL_LATENCY - 2);
    localparam logic [CNT_W-1:0] DRAIN_CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             supervisor_d;
    logic             load_use;
    logic             mul_done;
    ctrl_t            ctrl;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // Last MUL_WAIT cycle: the multiply result moves on, so the cycle behaves
    // like RUN (except that the still-visible ex_is_mul must not re-arm).
    assign mul_done = (state_q == MUL_WAIT) && (cnt_q == '0);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        ctrl         = CTRL_IDLE;
        state_d      = state_q;
        cnt_d        = cnt_q;
        supervisor_d = supervisor_mode;

        if (reset) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
        end else if (exc_valid) begin
            // Exception wins over everything, including a miss or a multiply.
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.exmem_flush = 1'b1;
            ctrl.pc_sel      = PC_SEL_EXC;
            state_d          = EXC_DRAIN;
            cnt_d            = DRAIN_CNT_INIT;
            supervisor_d     = 1'b1;
        end else if (exc_return && (state_q == RUN)) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.pc_sel      = PC_SEL_EPC;
            supervisor_d     = 1'b0;
        end else begin
            // Sequencer bookkeeping. The multiply timer keeps running under a
            // D-cache miss (the multiplier is not blocked by memory); the drain
            // window only counts cycles in which the front end is really held
            // by the drain itself.
            unique case (state_q)
                MUL_WAIT: begin
                    if (mul_done) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                EXC_DRAIN: begin
                    if (!d_cache_stall) begin
                        if (cnt_q == '0) begin
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                RUN: begin
                    if (!d_cache_stall && !ex_branch_taken && ex_is_mul) begin
                        state_d = MUL_WAIT;
                        cnt_d   = MUL_CNT_INIT;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase

            // Output priority. A taken branch under a miss is ignored here; EX
            // is held, so the branch is seen again once the miss clears.
            if (d_cache_stall) begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_stall  = 1'b1;
                ctrl.exmem_stall = 1'b1;
            end else if (state_q == EXC_DRAIN) begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_flush  = 1'b1;
            end else if ((state_q == MUL_WAIT) && !mul_done) begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_stall  = 1'b1;
                ctrl.exmem_flush = 1'b1;
            end else if (ex_branch_taken) begin
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_flush  = 1'b1;
                ctrl.pc_sel      = PC_SEL_BRANCH;
            end else if ((state_q == RUN) && ex_is_mul) begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_stall  = 1'b1;
                ctrl.exmem_flush = 1'b1;
            end else if (load_use || rob_full) begin
                ctrl.pc_stall    = 1'b1;
                ctrl.ifid_stall  = 1'b1;
                ctrl.idex_flush  = 1'b1;
            end
        end
    end

    // A register is never both held and cleared; the flush wins.
    assign pc_stall    = ctrl.pc_stall;
    assign ifid_stall  = ctrl.ifid_stall  & ~ctrl.ifid_flush;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_stall  = ctrl.idex_stall  & ~ctrl.idex_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_stall = ctrl.exmem_stall & ~ctrl.exmem_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign pc_sel      = ctrl.pc_sel;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RUN;
            cnt_q           <= '0;
            supervisor_mode <= 1'b1;
            stall_count     <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            supervisor_mode <= supervisor_d;
            if (ctrl.pc_stall) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl (MUL_LATENCY=4, DRAIN_CYCLES=2).
//   Control outputs are compared as one 9-bit vector:
//   {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
//    exmem_stall, exmem_flush, pc_sel[1:0]}.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam logic [8:0] V_IDLE  = 9'b0000000_00;
    localparam logic [8:0] V_RST   = 9'b0010101_00;
    localparam logic [8:0] V_LU    = 9'b1100100_00;  // also the drain response
    localparam logic [8:0] V_MUL   = 9'b1101001_00;
    localparam logic [8:0] V_DC    = 9'b1101010_00;
    localparam logic [8:0] V_BR    = 9'b0010100_01;
    localparam logic [8:0] V_EXC   = 9'b0010101_10;
    localparam logic [8:0] V_EPC   = 9'b0010100_11;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic        ex_mem_read, ex_is_mul, ex_branch_taken;
    logic        d_cache_stall, rob_full, exc_valid, exc_return;
    logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic        exmem_stall, exmem_flush, supervisor_mode;
    logic [1:0]  pc_sel;
    logic [31:0] stall_count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_sc = '0;

    pipeline_ctrl #(.MUL_LATENCY(4), .DRAIN_CYCLES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_is_mul       (ex_is_mul),
        .ex_branch_taken (ex_branch_taken),
        .d_cache_stall   (d_cache_stall),
        .rob_full        (rob_full),
        .exc_valid       (exc_valid),
        .exc_return      (exc_return),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_stall      (idex_stall),
        .idex_flush      (idex_flush),
        .exmem_stall     (exmem_stall),
        .exmem_flush     (exmem_flush),
        .pc_sel          (pc_sel),
        .supervisor_mode (supervisor_mode),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ctrl_vec();
        return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                exmem_stall, exmem_flush, pc_sel};
    endfunction

    // Advance one clock; the expected vector of the cycle just finished feeds
    // the reference stall counter.
    task automatic tick(input logic [8:0] exp);
        if (exp[8]) exp_sc = exp_sc + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (ctrl_vec() !== V_RST) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl_vec(), V_RST);
        end
        checks++;
        if (stall_count !== 32'd0 || supervisor_mode !== 1'b1) begin
            errors++; $display("FAIL reset_state: got sc=%0d sup=%b expected sc=0 sup=1",
                               stall_count, supervisor_mode);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ctrl_vec() !== V_IDLE) begin
            errors++; $display("FAIL reset_release: got %b expected %b", ctrl_vec(), V_IDLE);
        end
        tick(V_IDLE);
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #1;
        checks++;
        if (ctrl_vec() !== V_LU) begin
            errors++; $display("FAIL load_use_rs2: got %b expected %b", ctrl_vec(), V_LU);
        end
        tick(V_LU);
        ex_mem_read = 1'b0;  // load moved to MEM, bubble now in EX
        #1;
        checks++;
        if (ctrl_vec() !== V_IDLE) begin
            errors++; $display("FAIL load_use_release: got %b expected %b", ctrl_vec(), V_IDLE);
        end
        tick(V_IDLE);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        checks++;
        if (ctrl_vec() !== V_IDLE) begin
            errors++; $display("FAIL load_use_x0: got %b expected %b", ctrl_vec(), V_IDLE);
        end
        tick(V_IDLE);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        #1;
        checks++;
        if (ctrl_vec() !== V_IDLE) begin
            errors++; $display("FAIL load_use_unused_rs1: got %b expected %b", ctrl_vec(), V_IDLE);
        end
        id_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (ctrl_vec() !== V_LU) begin
            errors++; $display("FAIL load_use_rs1: got %b expected %b", ctrl_vec(), V_LU);
        end
        tick(V_LU);
        ex_mem_read = 1'b0; id_uses_rs1 = 1'b0;
        #1;
        checks++;
        if (stall_count !== exp_sc) begin
            errors++; $display("FAIL load_use_count: got %0d expected %0d", stall_count, exp_sc);
        end
    endtask

    task automatic test_rob_full();
        rob_full = 1'b1;
        #1;
        checks++;
        if (ctrl_vec() !== V_LU) begin
            errors++; $display("FAIL rob_full: got %b expected %b", ctrl_vec(), V_LU);
        end
        tick(V_LU);
        rob_full = 1'b0;
        #1;
    endtask

    task automatic test_multiply();
        logic [8:0] seq [4] = '{V_MUL, V_MUL, V_MUL, V_IDLE};
        ex_is_mul = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctrl_vec() !== seq[i]) begin
                errors++; $display("FAIL multiply_cycle%0d: got %b expected %b", i, ctrl_vec(), seq[i]);
            end
            tick(seq[i]);
            ex_is_mul = 1'b0;
        end
        #1;
        checks++;
        if (stall_count !== exp_sc) begin
            errors++; $display("FAIL multiply_count: got %0d expected %0d", stall_count, exp_sc);
        end
    endtask

    task automatic test_branch_under_miss();
        logic [8:0] seq [4] = '{V_DC, V_DC, V_BR, V_IDLE};
        ex_branch_taken = 1'b1; d_cache_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) d_cache_stall = 1'b0;
            if (i == 3) ex_branch_taken = 1'b0;
            #1;
            checks++;
            if (ctrl_vec() !== seq[i]) begin
                errors++; $display("FAIL branch_miss_cycle%0d: got %b expected %b", i, ctrl_vec(), seq[i]);
            end
            tick(seq[i]);
        end
    endtask

    task automatic test_privilege();
        logic [8:0] drain [3] = '{V_LU, V_LU, V_IDLE};
        exc_return = 1'b1;
        #1;
        checks++;
        if (ctrl_vec() !== V_EPC) begin
            errors++; $display("FAIL exc_return: got %b expected %b", ctrl_vec(), V_EPC);
        end
        tick(V_EPC);
        exc_return = 1'b0;
        #1;
        checks++;
        if (supervisor_mode !== 1'b0) begin
            errors++; $display("FAIL exc_return_mode: got %b expected 0", supervisor_mode);
        end
        exc_valid = 1'b1; exc_return = 1'b1;
        #1;
        checks++;
        if (ctrl_vec() !== V_EXC) begin
            errors++; $display("FAIL exc_and_return: got %b expected %b", ctrl_vec(), V_EXC);
        end
        tick(V_EXC);
        exc_valid = 1'b0; exc_return = 1'b0;
        #1;
        checks++;
        if (supervisor_mode !== 1'b1) begin
            errors++; $display("FAIL exc_and_return_mode: got %b expected 1", supervisor_mode);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctrl_vec() !== drain[i]) begin
                errors++; $display("FAIL priv_drain_cycle%0d: got %b expected %b", i, ctrl_vec(), drain[i]);
            end
            tick(drain[i]);
        end
    endtask

    task automatic test_exc_in_mul();
        logic [8:0] seq [6] = '{V_MUL, V_MUL, V_EXC, V_LU, V_LU, V_IDLE};
        exc_return = 1'b1;  // drop to user mode first
        #1;
        tick(V_EPC);
        exc_return = 1'b0;
        ex_is_mul = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) ex_is_mul = 1'b0;
            exc_valid = (i == 2);
            #1;
            checks++;
            if (ctrl_vec() !== seq[i]) begin
                errors++; $display("FAIL exc_mul_cycle%0d: got %b expected %b", i, ctrl_vec(), seq[i]);
            end
            if (i == 3) begin
                checks++;
                if (supervisor_mode !== 1'b1) begin
                    errors++; $display("FAIL exc_mul_mode: got %b expected 1", supervisor_mode);
                end
            end
            tick(seq[i]);
        end
        exc_valid = 1'b0;
        #1;
        checks++;
        if (stall_count !== exp_sc) begin
            errors++; $display("FAIL exc_mul_count: got %0d expected %0d", stall_count, exp_sc);
        end
    endtask

    task automatic test_reset_mid_drain();
        exc_valid = 1'b1;
        #1;
        tick(V_EXC);
        exc_valid = 1'b0;
        #1;
        checks++;
        if (ctrl_vec() !== V_LU) begin
            errors++; $display("FAIL drain_entry: got %b expected %b", ctrl_vec(), V_LU);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ctrl_vec() !== V_RST) begin
            errors++; $display("FAIL reset_in_drain: got %b expected %b", ctrl_vec(), V_RST);
        end
        tick(V_RST);
        exp_sc = '0;
        reset = 1'b0;
        #1;
        checks++;
        if (ctrl_vec() !== V_IDLE) begin
            errors++; $display("FAIL after_reset_run: got %b expected %b", ctrl_vec(), V_IDLE);
        end
        checks++;
        if (stall_count !== exp_sc) begin
            errors++; $display("FAIL after_reset_count: got %0d expected %0d", stall_count, exp_sc);
        end
        tick(V_IDLE);
    endtask

    task automatic test_wrap();
        force dut.stall_count = 32'hFFFF_FFFE;
        exp_sc = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count;
        d_cache_stall = 1'b1;
        #1;
        tick(V_DC);
        checks++;
        if (stall_count !== exp_sc) begin
            errors++; $display("FAIL wrap_max: got %h expected %h", stall_count, exp_sc);
        end
        tick(V_DC);
        checks++;
        if (stall_count !== exp_sc) begin
            errors++; $display("FAIL wrap_zero: got %h expected %h", stall_count, exp_sc);
        end
        d_cache_stall = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_is_mul = 1'b0; ex_branch_taken = 1'b0;
        d_cache_stall = 1'b0; rob_full = 1'b0; exc_valid = 1'b0; exc_return = 1'b0;

        test_reset();
        test_load_use();
        test_rob_full();
        test_multiply();
        test_branch_under_miss();
        test_privilege();
        test_exc_in_mul();
        test_reset_mid_drain();
        test_wrap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
